m_relu_pool_1_18: RTL and testbench
===================================

M_RELU_POOL_1_18 -- requirements
Module: m_relu_pool_1_18

Interface
REQ-001 Parameters SHALL be one per line: name, default, meaning.
- row_len, 88, valid conv outputs per input row
- num_rows, 88, input rows per feature map
- num_out, 1936, pooled outputs per map (44x44)
REQ-002 Ports SHALL be one per line: name, direction, width, meaning.
- clk_in, input, 1, single clock; all logic on rising edge
- rst_n, input, 1, reset; synchronous and active-high despite the name
- start, input, 1, stage enable, held high for the whole map
- map_in, input, 16, signed Q4.12 conv result
- save_in, input, 1, map_in valid strobe, driven from the conv stage's save
- map_out, output, 16, signed pooled and ReLU'd result
- save, output, 1, map_out valid strobe, one cycle per result
- ready, output, 1, high while the map is incomplete; low once num_out results have been emitted

Function
REQ-003 The block SHALL count only cycles with start=1 and save_in=1 as accepted pixels; gaps in save_in SHALL stall all counters.
REQ-004 The column counter col SHALL run 0..row_len-1 and wrap to 0, incrementing row.
REQ-005 The row counter row SHALL run 0..num_rows-1 and wrap to 0 after the last pixel, so the next map starts automatically.
REQ-006 On an accepted pixel with even col, the block SHALL latch map_in into a pair register.
REQ-007 On an accepted pixel with odd col, the block SHALL form hmax = signed max(pair register, map_in).
REQ-008 On even row, hmax SHALL be written to line buffer entry col>>1. The line buffer is 44 x 16 bits.
REQ-009 On odd row, the block SHALL form vmax = signed max(linebuf[col>>1], hmax). The comparison SHALL be 16-bit two's-complement; equal values pass either operand.
REQ-010 ReLU: map_out SHALL be 0 if vmax[15]=1, else vmax.
REQ-011 Latency: map_out and save SHALL be registered, with save=1 exactly one cycle after the accepted odd-row, odd-col pixel, and save=0 in all other cycles.
REQ-012 map_out SHALL hold its last value when save=0.
REQ-013 Each odd input row SHALL produce 44 save pulses; each full map SHALL produce num_out pulses.
REQ-014 out_cnt SHALL increment on each save pulse and saturate at num_out.
REQ-015 ready SHALL be registered and equal (out_cnt != num_out).
REQ-016 While ready=0, accepted pixels SHALL still advance counters but SHALL NOT produce save pulses or change out_cnt.
REQ-017 start=0 SHALL, on the next edge, clear col, row, the pair register, map_out and save. out_cnt and ready SHALL be held. Line buffer contents need not be cleared.
REQ-018 save_in=1 with start=0 SHALL be ignored.
REQ-019 The pixel at row 87, col 87 SHALL both emit the final result and wrap counters to (0,0) in the same cycle.

Reset
REQ-020 rst_n=1 at a clock edge SHALL force map_out=0, save=0, ready=1, out_cnt=0, col=0, row=0, and pair register=0. This applies at any point, including mid-row and mid-map.
REQ-021 The first accepted pixel after rst_n falls SHALL be treated as row 0, col 0.
REQ-022 The line buffer SHALL need no reset. Row 0 is always written before it is read.

Verification
REQ-023 Basic pool: row0 = 1,5,...; row1 = 3,2,...; all pixels positive -> first save pulse carries 5, one cycle after row1 col1.
REQ-024 ReLU: a 2x2 window of -4096,-1,-300,-2 -> map_out=0 with save=1.
REQ-025 Signed max: a window of -4096, 100, -1, 0x7FFF -> map_out=0x7FFF; a window of 0x8000, -2, -3, -5 -> map_out=0.
REQ-026 Stalls: save_in toggled 1,0,1,0 across a full map -> exactly 1936 save pulses, results identical to the unstalled run, then ready=0.
REQ-027 Saturation and wrap: feed 2 full maps after reset -> 1936 pulses only, ready stays 0, counters end at (0,0).
REQ-028 Mid-operation interruptions:
- rst_n pulsed at row 5, col 40 -> outputs zero next cycle, ready=1; the next pixel is treated as (0,0).
- start dropped at row 5 -> col and row cleared, out_cnt retained.

Source files
------------

// File: rtl/m_relu_pool_1_18.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : m_relu_pool_1_18
// Brief    : Streaming 2x2 signed max-pool followed by ReLU over a conv map.
// Revision : 1.0 - initial release
// ============================================================================
module m_relu_pool_1_18 #(
    parameter int row_len  = 88,
    parameter int num_rows = 88,
    parameter int num_out  = 1936
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] map_in,
    input  logic        save_in,
    output logic [15:0] map_out,
    output logic        save,
    output logic        ready
);

    localparam int c_col_w    = $clog2(row_len);
    localparam int c_row_w    = $clog2(num_rows);
    localparam int c_cnt_w    = $clog2(num_out + 1);
    localparam int c_lb_depth = row_len / 2;

    localparam logic [c_col_w-1:0] c_col_last = c_col_w'(row_len - 1);
    localparam logic [c_row_w-1:0] c_row_last = c_row_w'(num_rows - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max  = c_cnt_w'(num_out);

    logic [c_col_w-1:0] r_col;
    logic [c_row_w-1:0] r_row;
    logic [15:0]        r_pair;
    logic [15:0]        r_linebuf [c_lb_depth];
    logic [c_cnt_w-1:0] r_out_cnt;
    logic [15:0]        r_map_out;
    logic               r_save;
    logic               r_ready;

    logic               w_accept;
    logic               w_emit;
    logic [c_col_w-2:0] w_lb_idx;
    logic [15:0]        w_lb_rd;
    logic [15:0]        w_hmax;
    logic [15:0]        w_vmax;
    logic [15:0]        w_relu;
    logic [c_cnt_w-1:0] w_cnt_nxt;

    assign w_accept  = start & save_in;
    assign w_lb_idx  = r_col[c_col_w-1:1];
    assign w_lb_rd   = r_linebuf[w_lb_idx];
    assign w_hmax    = ($signed(r_pair) > $signed(map_in)) ? r_pair : map_in;
    assign w_vmax    = ($signed(w_lb_rd) > $signed(w_hmax)) ? w_lb_rd : w_hmax;
    assign w_relu    = w_vmax[15] ? 16'h0000 : w_vmax;
    // Results are only produced while the map is still incomplete.
    assign w_emit    = w_accept & r_col[0] & r_row[0] & r_ready;
    assign w_cnt_nxt = r_out_cnt + 1'b1;

    // Even rows park their horizontal maxima here; row 0 always fills it first.
    always_ff @(posedge clk_in) begin
        if (!rst_n && w_accept && r_col[0] && !r_row[0]) begin
            r_linebuf[w_lb_idx] <= w_hmax;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_n) begin
            r_col     <= '0;
            r_row     <= '0;
            r_pair    <= '0;
            r_map_out <= '0;
            r_save    <= 1'b0;
            r_out_cnt <= '0;
            r_ready   <= 1'b1;
        end else if (!start) begin
            r_col     <= '0;
            r_row     <= '0;
            r_pair    <= '0;
            r_map_out <= '0;
            r_save    <= 1'b0;
        end else begin
            r_save <= 1'b0;
            if (w_accept) begin
                if (r_col == c_col_last) begin
                    r_col <= '0;
                    r_row <= (r_row == c_row_last) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
                if (!r_col[0]) begin
                    r_pair <= map_in;
                end
                if (w_emit) begin
                    r_map_out <= w_relu;
                    r_save    <= 1'b1;
                    r_out_cnt <= w_cnt_nxt;
                    r_ready   <= (w_cnt_nxt != c_cnt_max);
                end
            end
        end
    end

    assign map_out = r_map_out;
    assign save    = r_save;
    assign ready   = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_m_relu_pool_1_18.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_m_relu_pool_1_18
// Brief    : Directed bench for m_relu_pool_1_18 with a per-cycle image model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_m_relu_pool_1_18;

    localparam int ROW_LEN  = 88;
    localparam int NUM_ROWS = 88;
    localparam int NUM_OUT  = 1936;
    localparam int MAP_PIX  = ROW_LEN * NUM_ROWS;

    logic        clk_in = 1'b0;
    logic        rst_n  = 1'b1;
    logic        start  = 1'b0;
    logic        save_in = 1'b0;
    logic [15:0] map_in = 16'h0000;
    logic [15:0] map_out;
    logic        save;
    logic        ready;

    always #5 clk_in = ~clk_in;

    m_relu_pool_1_18 #(
        .row_len (ROW_LEN),
        .num_rows(NUM_ROWS),
        .num_out (NUM_OUT)
    ) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .start  (start),
        .map_in (map_in),
        .save_in(save_in),
        .map_out(map_out),
        .save   (save),
        .ready  (ready)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int pos    = 0;
    bit chk_en = 1'b1;

    logic [15:0] obs[$];
    logic [15:0] ref_b[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic signed [15:0] smax(input logic signed [15:0] a,
                                                input logic signed [15:0] b);
        return (a > b) ? a : b;
    endfunction

    // Mode 0: small positive image with hand-built windows in the top-left corner.
    // Mode 1: deterministic mixed-sign image.
    function automatic logic [15:0] pix(input int mode, input int r, input int c);
        if (mode == 0) begin
            if (r < 2 && c < 8) begin
                case (r * 8 + c)
                    0:  return 16'd1;
                    1:  return 16'd5;
                    2:  return 16'hF000;
                    3:  return 16'hFFFF;
                    4:  return 16'hF000;
                    5:  return 16'd100;
                    6:  return 16'h8000;
                    7:  return 16'hFFFE;
                    8:  return 16'd3;
                    9:  return 16'd2;
                    10: return 16'hFED4;
                    11: return 16'hFFFE;
                    12: return 16'hFFFF;
                    13: return 16'h7FFF;
                    14: return 16'hFFFD;
                    default: return 16'hFFFB;
                endcase
            end
            return 16'((r * 7 + c * 3) % 50 + 1);
        end
        return 16'((r * 1237 + c * 4513 + r * c * 97) ^ 32'h5A5A);
    endfunction

    // Model: the image as a 2-D array; each odd/odd pixel closes a 2x2 window.
    always @(posedge clk_in) begin : p_cmp
        logic signed [15:0] img [NUM_ROWS][ROW_LEN];
        logic signed [15:0] mx;
        int m_n, m_cnt, r, c;
        logic [15:0] exp_out;
        logic exp_save, exp_ready;
        if (rst_n) begin
            m_n = 0; m_cnt = 0; exp_out = 16'h0; exp_save = 1'b0;
        end else if (!start) begin
            m_n = 0; exp_out = 16'h0; exp_save = 1'b0;
        end else begin
            exp_save = 1'b0;
            if (save_in) begin
                r = m_n / ROW_LEN;
                c = m_n % ROW_LEN;
                img[r][c] = map_in;
                if (r % 2 == 1 && c % 2 == 1 && m_cnt < NUM_OUT) begin
                    mx = smax(smax(img[r-1][c-1], img[r-1][c]), smax(img[r][c-1], img[r][c]));
                    exp_out  = (mx < 0) ? 16'h0 : mx;
                    exp_save = 1'b1;
                    m_cnt++;
                end
                m_n = (m_n + 1) % MAP_PIX;
            end
        end
        exp_ready = (m_cnt != NUM_OUT);
        #1;
        if (chk_en) begin
            check("save", save, exp_save);
            check("map_out", map_out, exp_out);
            check("ready", ready, exp_ready);
        end
        if (save) obs.push_back(map_out);
    end

    task automatic feed(input int mode, input int n, input bit stall);
        for (int k = 0; k < n; k++) begin
            @(negedge clk_in);
            start = 1'b1; save_in = 1'b1;
            map_in = pix(mode, pos / ROW_LEN, pos % ROW_LEN);
            pos = (pos + 1) % MAP_PIX;
            if (stall) begin
                @(negedge clk_in);
                save_in = 1'b0; map_in = 16'hA5A5;
            end
        end
        @(posedge clk_in);
        #2;
    endtask

    task automatic do_reset(input bit sin);
        @(negedge clk_in);
        rst_n = 1'b1; start = 1'b1; save_in = sin; map_in = 16'h1234;
        @(negedge clk_in);
        rst_n = 1'b0; save_in = 1'b0;
        pos = 0;
        obs.delete();
    endtask

    task automatic drop_start();
        @(negedge clk_in);
        start = 1'b0; save_in = 1'b1; map_in = 16'h7777;
        pos = 0;
        @(posedge clk_in);
        #2;
    endtask

    initial begin : p_watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : p_stim
        int mism;
        do_reset(1'b0);
        check("rst_save", save, 1'b0);
        check("rst_map_out", map_out, 16'h0);
        check("rst_ready", ready, 1'b1);

        // Basic pool, ReLU and signed-max windows at fixed positions.
        feed(0, 90, 1'b0);
        check("first_save", save, 1'b1);
        check("first_val", map_out, 16'd5);
        feed(0, 2, 1'b0);
        check("relu_val", map_out, 16'h0000);
        check("relu_save", save, 1'b1);
        feed(0, 2, 1'b0);
        check("smax_pos", map_out, 16'h7FFF);
        feed(0, 2, 1'b0);
        check("smax_neg", map_out, 16'h0000);
        feed(0, MAP_PIX - 96, 1'b0);
        check("mapA_pulses", obs.size(), NUM_OUT);
        check("mapA_ready", ready, 1'b0);

        // Two back-to-back maps: saturation and automatic wrap.
        do_reset(1'b0);
        check("rst2_ready", ready, 1'b1);
        feed(1, MAP_PIX, 1'b0);
        ref_b = obs;
        feed(1, MAP_PIX, 1'b0);
        check("sat_pulses", obs.size(), NUM_OUT);
        check("sat_ready", ready, 1'b0);
        check("wrap_col", dut.r_col, 0);
        check("wrap_row", dut.r_row, 0);
        check("sat_cnt", dut.r_out_cnt, NUM_OUT);

        // Stalled map must reproduce the unstalled results.
        do_reset(1'b0);
        feed(1, MAP_PIX, 1'b1);
        check("stall_pulses", obs.size(), NUM_OUT);
        mism = 0;
        for (int i = 0; i < NUM_OUT; i++)
            if (i >= obs.size() || i >= ref_b.size() || obs[i] !== ref_b[i]) mism++;
        check("stall_match", mism, 0);
        check("stall_ready", ready, 1'b0);

        // Reset in the middle of row 5.
        feed(0, 5 * ROW_LEN + 40, 1'b0);
        do_reset(1'b1);
        check("midrst_save", save, 1'b0);
        check("midrst_map_out", map_out, 16'h0);
        check("midrst_ready", ready, 1'b1);
        check("midrst_col", dut.r_col, 0);
        check("midrst_row", dut.r_row, 0);
        feed(0, 90, 1'b0);
        check("midrst_first", map_out, 16'd5);
        check("midrst_first_save", save, 1'b1);

        // Start dropped at row 5, col 40.
        feed(0, 5 * ROW_LEN + 40 - 90, 1'b0);
        drop_start();
        check("drop_col", dut.r_col, 0);
        check("drop_row", dut.r_row, 0);
        check("drop_pair", dut.r_pair, 0);
        check("drop_cnt", dut.r_out_cnt, 108);
        check("drop_save", save, 1'b0);
        check("drop_map_out", map_out, 16'h0);
        check("drop_ready", ready, 1'b1);
        feed(0, 90, 1'b0);
        check("drop_first", map_out, 16'd5);
        check("drop_first_save", save, 1'b1);

        @(negedge clk_in);
        save_in = 1'b0;
        @(negedge clk_in);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
